// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock FIFO with handshake acks and occupancy flags
module fifo_sync_core #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = FIFO_DEPTH[CW-1:0];

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;

    assign full        = count_q == FULL_C;
    assign empty       = count_q == '0;
    assign almostfull  = count_q == FULL_C - CW'(1);
    assign almostempty = count_q == CW'(1);
    assign data_out    = data_out_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // A full FIFO rejects writes and an empty one rejects reads, even when the
    // opposite side is active in the same cycle.
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = (wr_acc && !rd_acc) ? count_q + CW'(1) :
                     (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
        data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    end

    // Pointers, occupancy, read data and handshake status; reset wins over requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage array is never cleared; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: directed self-checking bench for fifo_sync_core
module tb_fifo_sync_core;
    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [15:0] data_in, data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    int          checks = 0;
    int          errors = 0;

    fifo_sync_core #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow), .full(full), .empty(empty),
        .almostfull(almostfull), .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic rd, input logic [15:0] d);
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        step();
    endtask

    initial begin
        drive(1, 1, 1, 16'h0000);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almostfull, 0);
        check("rst_ae", almostempty, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        check("rst_dout", data_out, 0);

        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 0, 16'(i));
            check("fill_ack", wr_ack, 1);
            check("fill_af", almostfull, i == 7);
            check("fill_full", full, i == 8);
        end
        drive(0, 1, 0, 16'h0009);
        check("ovf_flag", overflow, 1);
        check("ovf_ack", wr_ack, 0);
        check("ovf_full", full, 1);

        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 16'h0000);
            check("drain_dout", data_out, i);
            check("drain_ae", almostempty, i == 7);
            check("drain_empty", empty, i == 8);
            check("drain_udf", underflow, 0);
        end
        drive(0, 0, 1, 16'h0000);
        check("udf_flag", underflow, 1);
        check("udf_dout", data_out, 16'h0008);
        check("udf_empty", empty, 1);

        drive(0, 1, 1, 16'hABCD);
        check("we_ack", wr_ack, 1);
        check("we_udf", underflow, 1);
        check("we_ae", almostempty, 1);
        check("we_empty", empty, 0);
        check("we_dout", data_out, 16'h0008);

        for (int i = 1; i <= 7; i++) drive(0, 1, 0, 16'h0100 + 16'(i));
        check("refill_full", full, 1);
        drive(0, 1, 1, 16'hFFFF);
        check("fb_ovf", overflow, 1);
        check("fb_ack", wr_ack, 0);
        check("fb_udf", underflow, 0);
        check("fb_af", almostfull, 1);
        check("fb_dout", data_out, 16'hABCD);

        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, 16'h0000);
            check("to4_dout", data_out, 16'h0100 + 16'(i));
        end
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 1, 16'h0200 + 16'(k));
            check("wrap_dout", data_out, k < 4 ? 16'h0104 + 16'(k) : 16'h0200 + 16'(k - 4));
            check("wrap_flags", {full, empty, almostfull, almostempty}, 4'b0000);
            check("wrap_ack", wr_ack, 1);
        end

        drive(1, 0, 0, 16'h0000);
        check("rst2_empty", empty, 1);
        for (int i = 1; i <= 5; i++) drive(0, 1, 0, 16'h0300 + 16'(i));
        check("five_flags", {full, empty, almostfull, almostempty}, 4'b0000);
        drive(1, 1, 0, 16'h0999);
        check("rst3_empty", empty, 1);
        check("rst3_ack", wr_ack, 0);
        drive(0, 1, 0, 16'h1234);
        check("post_ack", wr_ack, 1);
        check("post_ae", almostempty, 1);
        drive(0, 0, 1, 16'h0000);
        check("post_dout", data_out, 16'h1234);
        check("post_empty", empty, 1);
        drive(0, 0, 1, 16'h0000);
        check("post_udf", underflow, 1);
        check("post_hold", data_out, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
